// File: rtl/rx_psdu_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_psdu_deframer_pkg
// Description : Shared types and constants for the PSDU deframer slice.
// Revision    : 1.0
// ============================================================================
package rx_psdu_deframer_pkg;

    localparam int SEED_BITS    = 7;
    localparam int SERVICE_BITS = 16;
    localparam int LEN_W        = 12;
    localparam int LFSR_W       = 7;
    localparam int TAP_A        = 7;
    localparam int TAP_B        = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SERVICE = 3'd2,
        ST_PSDU    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rx_psdu_deframer_lfsr127_ce.sv
`default_nettype none
// ============================================================================
// Module      : lfsr127_ce
// Description : 7-bit frame-synchronous descrambler core (x^7 + x^4 + 1).
// Revision    : 1.0
// ============================================================================
module lfsr127_ce
    import rx_psdu_deframer_pkg::*;
(
    input  logic iClk,
    input  logic iRst,
    input  logic iCE,
    input  logic iSEN,
    input  logic iData,
    output logic oData
);

    logic [LFSR_W:1] lfsr_q;
    logic [LFSR_W:1] lfsr_d;
    logic            w_fb;

    // Seed mode loads raw bits (they are the scrambler sequence itself);
    // run mode feeds the tap XOR back into stage 1.
    always_comb begin
        w_fb   = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
        oData  = iSEN ? 1'b0 : (iData ^ w_fb);
        lfsr_d = lfsr_q;
        if (iCE) begin
            lfsr_d = {lfsr_q[LFSR_W-1:1], (iSEN ? iData : w_fb)};
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_psdu_deframer.sv
`default_nettype none
// ============================================================================
// Module      : rx_psdu_deframer
// Description : Descrambles SERVICE+PSDU bits and packs PSDU bytes LSB-first.
// Revision    : 1.0
// ============================================================================
module rx_psdu_deframer
    import rx_psdu_deframer_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iLength,
    input  logic             iValid,
    input  logic             iData,
    output logic [7:0]       oByte,
    output logic             oByteValid,
    output logic             oBusy,
    output logic             oDone,
    output logic             oServiceErr
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       svc_cnt_q, svc_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld_q, byte_vld_d;
    logic             svc_err_q, svc_err_d;

    logic             w_lfsr_ce;
    logic             w_lfsr_sen;
    logic             w_descr;
    logic             w_seed_last;
    logic             w_svc_last;
    logic             w_byte_last;
    logic             w_frame_last;
    logic [7:0]       w_shift;

    lfsr127_ce u_lfsr (
        .iClk  (iClk),
        .iRst  (iRst),
        .iCE   (w_lfsr_ce),
        .iSEN  (w_lfsr_sen),
        .iData (iData),
        .oData (w_descr)
    );

    assign w_seed_last  = (svc_cnt_q == 4'(SEED_BITS - 1));
    assign w_svc_last   = (svc_cnt_q == 4'(SERVICE_BITS - 1));
    assign w_byte_last  = (bit_cnt_q == 3'd7);
    assign w_frame_last = w_byte_last && ((byte_cnt_q + LEN_W'(1)) == len_q);
    assign w_shift      = {w_descr, shreg_q[7:1]};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. iStart wins from every state, including DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (iStart) begin
            state_d = ST_SEED;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_SEED: begin
                    if (iValid && w_seed_last) begin
                        state_d = ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (iValid && w_svc_last) begin
                        state_d = (len_q == '0) ? ST_DONE : ST_PSDU;
                    end
                end
                ST_PSDU: begin
                    if (iValid && w_frame_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs and descrambler control
    // ------------------------------------------------------------------------
    always_comb begin
        oBusy      = (state_q != ST_IDLE);
        oDone      = (state_q == ST_DONE);
        w_lfsr_sen = (state_q == ST_SEED);
        w_lfsr_ce  = iValid && !iStart &&
                     ((state_q == ST_SEED) || (state_q == ST_SERVICE) ||
                      (state_q == ST_PSDU));
    end

    // ------------------------------------------------------------------------
    // Counters, byte packer and SERVICE error flag
    // ------------------------------------------------------------------------
    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        svc_cnt_d  = svc_cnt_q;
        shreg_d    = shreg_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        svc_err_d  = svc_err_q;

        if (iStart) begin
            // Fresh frame (or abort): partial byte and error history are dropped.
            len_d      = iLength;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            svc_cnt_d  = '0;
            shreg_d    = '0;
            svc_err_d  = 1'b0;
        end else if (iValid) begin
            case (state_q)
                ST_SEED: begin
                    svc_cnt_d = svc_cnt_q + 4'd1;
                end
                ST_SERVICE: begin
                    svc_cnt_d = svc_cnt_q + 4'd1;
                    if (w_descr) begin
                        svc_err_d = 1'b1;
                    end
                end
                ST_PSDU: begin
                    shreg_d   = w_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (w_byte_last) begin
                        byte_d     = w_shift;
                        byte_vld_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            svc_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            svc_err_q  <= 1'b0;
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            svc_cnt_q  <= svc_cnt_d;
            shreg_q    <= shreg_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            svc_err_q  <= svc_err_d;
        end
    end

    assign oByte       = byte_q;
    assign oByteValid  = byte_vld_q;
    assign oServiceErr = svc_err_q;

endmodule
`default_nettype wire

// File: doc/rx_psdu_deframer.md
RX_PSDU_DEFRAMER -- requirements
Module: rx_psdu_deframer

Interface
REQ-001 SHALL have port iClk, input, 1: rising-edge clock.
REQ-002 SHALL have port iRst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port iStart, input, 1: one-cycle pulse marking frame start; captures iLength.
REQ-004 SHALL have port iLength, input, 12: PSDU length in bytes from the decoded SIGNAL field, range 0..4095.
REQ-005 SHALL have port iValid, input, 1: qualifies iData; one decoded bit per asserted cycle; gaps allowed.
REQ-006 SHALL have port iData, input, 1: scrambled bit from the Viterbi decoder, SERVICE bit 0 first.
REQ-007 SHALL have port oByte, output, 8: descrambled PSDU byte, first received bit in bit 0.
REQ-008 SHALL have port oByteValid, output, 1: one-cycle strobe qualifying oByte.
REQ-009 SHALL have port oBusy, output, 1: high from the cycle after iStart until oDone.
REQ-010 SHALL have port oDone, output, 1: one-cycle pulse at frame end.
REQ-011 SHALL have port oServiceErr, output, 1: sticky flag; descrambled SERVICE bits 7..15 not all zero.

Function
REQ-012 SHALL implement FSM states IDLE, SEED, SERVICE, PSDU, DONE.
REQ-013 IDLE: iStart -> SEED; iValid/iData ignored; iValid in the iStart cycle is not counted.
REQ-014 SEED: the first 7 valid bits SHALL be loaded into the LFSR as seed, LFSR[1] <= iData, shifting toward LFSR[7]; after the 7th bit -> SERVICE.
REQ-015 SERVICE: the next 9 valid bits SHALL be descrambled as iData ^ LFSR[7] ^ LFSR[4]; feedback LFSR[7]^LFSR[4] enters LFSR[1].
REQ-016 SHALL set oServiceErr if any SERVICE-phase descrambled bit is 1.
REQ-017 After the 9th SERVICE bit: if length = 0 -> DONE, else -> PSDU.
REQ-018 PSDU: valid bits SHALL be descrambled and shifted into a byte register LSB-first, using a 3-bit bit counter and a 12-bit byte counter.
REQ-019 SHALL drive oByte/oByteValid registered, one cycle after the iValid cycle carrying the byte's 8th bit.
REQ-020 After byte number = captured length -> DONE; further valid bits are ignored (tail/pad discarded).
REQ-021 DONE SHALL last one cycle with oDone = 1, then -> IDLE.
REQ-022 The LFSR SHALL advance only on iValid cycles; on cycles without iValid it holds.
REQ-023 iStart in any non-IDLE state SHALL abort the frame and restart at SEED. Any byte in progress is discarded. oServiceErr clears. No oDone for the aborted frame.
REQ-024 iStart in the DONE cycle SHALL be honoured. oDone still pulses; the next state is SEED.
REQ-025 oServiceErr SHALL clear only on iStart or reset.
REQ-026 Input-to-output latency SHALL be exactly 1 cycle; no backpressure exists.

Reset
REQ-027 iRst SHALL force FSM to IDLE immediately, including mid-frame.
REQ-028 iRst SHALL force LFSR, counters, oByte = 0 and oByteValid, oBusy, oDone, oServiceErr = 0.
REQ-029 After reset release, the block SHALL wait for iStart; no partial-frame output.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, SEED_BITS=7, SERVICE_BITS=16, LEN_W=12 and the LFSR taps (7,4).
REQ-031 SHALL instantiate one sub-module, lfsr127_ce: a 7-bit frame-synchronous descrambler core with ports iCE, iSEN, iData, oData.
REQ-032 Control (FSM, counters, byte packer, error flag) SHALL reside in rx_psdu_deframer.

Verification
REQ-033 Bench SHALL scramble 16 zero SERVICE bits + 0xA5 with seed 7'b1011101, contiguous iValid, iLength=1. Required: one strobe with oByte=0xA5; oDone in the same cycle; oServiceErr=0.
REQ-034 Bench SHALL send iLength=3 with payload 0x01,0x80,0xFF and random 1-3 cycle iValid gaps. Required: three strobes in order; oDone coincides with the third.
REQ-035 Bench SHALL set descrambled SERVICE bit 12=1. Required: oServiceErr=1 stays high through oDone and clears on the next iStart.
REQ-036 Bench SHALL send iLength=0. Required: oDone after the 16th valid bit; no oByteValid.
REQ-037 Bench SHALL issue iStart during the 2nd PSDU byte, then a new frame with iLength=1, payload 0x3C. Required: no oDone for the first frame; a single 0x3C byte.
REQ-038 Bench SHALL assert iRst during PSDU. Required: all outputs 0 in the same cycle; IDLE; 20 further valid bits produce no output.
